// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: registered, handshaked RV32I execute stage with a one-entry output register.
// Define EX_MDU_EN to add the iterative RV32M multiply/divide unit (IDLE/BUSY/DONE FSM).
module ex_stage_mdu #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic             alub_sel,
    input  logic [XLEN-1:0]  rf_rd1,
    input  logic [XLEN-1:0]  rf_rd2,
    input  logic [XLEN-1:0]  sext_ext,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_c,
    output logic             alu_zero,
    output logic             alu_sgn,
    output logic [TAG_W-1:0] out_tag
);
    localparam int SHW = $clog2(XLEN);

    logic signed [XLEN-1:0] op_a, op_b;
    logic [XLEN-1:0]        alu_res, load_val, res_p1;
    logic [TAG_W-1:0]       load_tag, tag_p1;
    logic                   vld_p1, out_free, accept, load_out;

    function automatic logic [XLEN-1:0] alu_f(input logic [4:0] op,
                                              input logic signed [XLEN-1:0] a,
                                              input logic signed [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            5'h00:   alu_f = a + b;
            5'h01:   alu_f = a - b;
            5'h02:   alu_f = a & b;
            5'h03:   alu_f = a | b;
            5'h04:   alu_f = a ^ b;
            5'h05:   alu_f = a << sh;
            5'h06:   alu_f = $unsigned(a) >> sh;
            5'h07:   alu_f = a >>> sh;
            5'h08:   alu_f = {{(XLEN-1){1'b0}}, a < b};
            5'h09:   alu_f = {{(XLEN-1){1'b0}}, $unsigned(a) < $unsigned(b)};
            default: alu_f = '0;
        endcase
    endfunction

    assign op_a     = rf_rd1;
    assign op_b     = alub_sel ? sext_ext : rf_rd2;
    assign alu_res  = alu_f(alu_op, op_a, op_b);
    assign out_free = !vld_p1 || out_ready;

`ifdef EX_MDU_EN
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]       cnt, cnt_nxt;
    logic [2:0]          mop, mop_p0;
    logic                is_mop, sa, sb, mdu_load;
    logic [XLEN-1:0]     mag_a, mag_b, hi_step, lo_step, quo_fix, rem_fix, mdu_res;
    logic [XLEN-1:0]     hi_p0, lo_p0, mag_b_p0, a_raw_p0;
    logic [TAG_W-1:0]    tag_p0;
    logic                neg_q_p0, neg_r_p0, dz_p0;
    logic [XLEN:0]       add_sum, r_sh, r_diff;
    logic [2*XLEN-1:0]   prod, prod_fix;

    assign mop    = alu_op[2:0];
    assign is_mop = (alu_op[4:3] == 2'b10);
    assign sa     = rf_rd1[XLEN-1] && (mop == 3'd1 || mop == 3'd2 || mop == 3'd4 || mop == 3'd6);
    assign sb     = op_b[XLEN-1] && (mop == 3'd1 || mop == 3'd4 || mop == 3'd6);
    assign mag_a  = sa ? -rf_rd1 : rf_rd1;
    assign mag_b  = sb ? -op_b : op_b;

    assign in_ready = !flush && (state == IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign load_out = (accept && !is_mop) || mdu_load;
    assign load_val = mdu_load ? mdu_res : alu_res;
    assign load_tag = mdu_load ? tag_p0 : in_tag;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mdu_load  = 1'b0;
        case (state)
            IDLE: if (accept && is_mop) begin
                state_nxt = BUSY;
                cnt_nxt   = CW'(XLEN);
            end
            BUSY: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE: if (out_free) begin
                mdu_load  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            mdu_load  = 1'b0;
        end
    end

    // Iteration step: hi/lo hold the partial product (mul) or remainder/quotient (div)
    always_comb begin
        add_sum = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, mag_b_p0} : '0);
        r_sh    = {hi_p0, lo_p0[XLEN-1]};
        r_diff  = r_sh - {1'b0, mag_b_p0};
        if (mop_p0[2]) begin
            if (!r_diff[XLEN]) begin
                hi_step = r_diff[XLEN-1:0];
                lo_step = {lo_p0[XLEN-2:0], 1'b1};
            end else begin
                hi_step = r_sh[XLEN-1:0];
                lo_step = {lo_p0[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_step = add_sum[XLEN:1];
            lo_step = {add_sum[0], lo_p0[XLEN-1:1]};
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (accept && is_mop) begin
            hi_p0    <= '0;
            lo_p0    <= mag_a;
            mag_b_p0 <= mag_b;
            a_raw_p0 <= rf_rd1;
            mop_p0   <= mop;
            neg_q_p0 <= sa ^ sb;
            neg_r_p0 <= sa;
            dz_p0    <= (op_b == '0);
            tag_p0   <= in_tag;
        end else if (state == BUSY) begin
            hi_p0 <= hi_step;
            lo_p0 <= lo_step;
        end
    end

    // DONE: sign fix-up and result select
    always_comb begin
        prod     = {hi_p0, lo_p0};
        prod_fix = neg_q_p0 ? -prod : prod;
        quo_fix  = neg_q_p0 ? -lo_p0 : lo_p0;
        rem_fix  = neg_r_p0 ? -hi_p0 : hi_p0;
        case (mop_p0)
            3'd0:             mdu_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: mdu_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       mdu_res = dz_p0 ? '1 : quo_fix;
            default:          mdu_res = dz_p0 ? a_raw_p0 : rem_fix;
        endcase
    end
`else
    assign in_ready = !flush && out_free;
    assign accept   = in_valid && in_ready;
    assign load_out = accept;
    assign load_val = alu_res;
    assign load_tag = in_tag;
`endif

    // Output register stage
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            vld_p1 <= 1'b0;
            res_p1 <= '0;
            tag_p1 <= '0;
        end else begin
            if (flush)          vld_p1 <= 1'b0;
            else if (load_out)  vld_p1 <= 1'b1;
            else if (out_ready) vld_p1 <= 1'b0;
            if (load_out) begin
                res_p1 <= load_val;
                tag_p1 <= load_tag;
            end
        end
    end

    assign out_valid = vld_p1;
    assign alu_c     = res_p1;
    assign out_tag   = tag_p1;
    assign alu_zero  = (res_p1 == '0);
    assign alu_sgn   = res_p1[XLEN-1];
endmodule
